// File: rtl/ddr_init_responder_if.sv
// ============================================================================
// ddr_init_responder_if: DDR4 command pins in, mode registers and status out.
// Rev 1.0
// ============================================================================
`default_nettype none

interface ddr_init_responder_if;
  logic        CKE;
  logic        cs_n;
  logic        act_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic [1:0]  BG;
  logic [1:0]  BA;
  logic [13:0] A;

  logic [13:0] mr0;
  logic [13:0] mr1;
  logic [13:0] mr2;
  logic [13:0] mr3;
  logic [13:0] mr4;
  logic [13:0] mr5;
  logic [13:0] mr6;
  logic [6:0]  mr_written;
  logic [3:0]  cl_code;
  logic [1:0]  bl_code;
  logic [1:0]  al_code;
  logic [2:0]  cwl_code;
  logic        rd_pre;
  logic        wr_pre;
  logic        init_done;
  logic        init_err;
  logic [2:0]  err_code;

  modport master (
    output CKE, cs_n, act_n, ras_n, cas_n, we_n, BG, BA, A,
    input  mr0, mr1, mr2, mr3, mr4, mr5, mr6, mr_written,
    input  cl_code, bl_code, al_code, cwl_code, rd_pre, wr_pre,
    input  init_done, init_err, err_code
  );

  modport slave (
    input  CKE, cs_n, act_n, ras_n, cas_n, we_n, BG, BA, A,
    output mr0, mr1, mr2, mr3, mr4, mr5, mr6, mr_written,
    output cl_code, bl_code, al_code, cwl_code, rd_pre, wr_pre,
    output init_done, init_err, err_code
  );
endinterface

`default_nettype wire

// File: rtl/ddr_init_responder.sv
// ============================================================================
// ddr_init_responder: DRAM-side checker/recorder of the DDR4 init sequence.
// Rev 1.0
// ============================================================================
`default_nettype none

module ddr_init_responder #(
  parameter int T_XPR = 24,
  parameter int T_MRD = 8,
  parameter int T_MOD = 24,
  parameter int T_ZQ  = 512,
  parameter int CNT_W = 10
) (
  input  logic                 CK_t,
  input  logic                 reset_n,
  ddr_init_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_RST     = 3'd0,
    S_XPR     = 3'd1,
    S_MRS_SEQ = 3'd2,
    S_ZQ      = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] c_t_xpr   = CNT_W'(T_XPR);
  localparam logic [CNT_W-1:0] c_t_mrd   = CNT_W'(T_MRD);
  localparam logic [CNT_W-1:0] c_t_mod   = CNT_W'(T_MOD);
  localparam logic [CNT_W-1:0] c_zq_last = CNT_W'(T_ZQ - 1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [13:0]       mr_q [7];
  logic [6:0]        mr_written_q;
  logic              init_done_q;
  logic              init_err_q;
  logic [2:0]        err_code_q;

  logic              is_idle;
  logic              is_mrs;
  logic              is_zqcl;
  logic              is_other;
  logic [2:0]        mrs_idx;
  logic [2:0]        viol;
  logic [CNT_W-1:0]  cnt_inc;
  logic              unused_bg1;

  assign unused_bg1 = bus.BG[1];

  assign is_idle  = bus.cs_n |
                    (bus.act_n & bus.ras_n & bus.cas_n & bus.we_n);
  assign is_mrs   = ~bus.cs_n & bus.act_n & ~bus.ras_n & ~bus.cas_n & ~bus.we_n;
  assign is_zqcl  = ~bus.cs_n & bus.act_n & bus.ras_n & bus.cas_n & ~bus.we_n
                    & bus.A[10];
  assign is_other = ~is_idle & ~is_mrs & ~is_zqcl;
  assign mrs_idx  = {bus.BG[0], bus.BA};
  assign cnt_inc  = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + CNT_W'(1);

  // Violation cause for this edge, 0 = none; branch order is the priority.
  always_comb begin
    viol = 3'd0;
    if (state_q == S_XPR || state_q == S_MRS_SEQ) begin
      if (!bus.CKE)                                          viol = 3'd6;
      else if (is_mrs && mrs_idx == 3'd7)                    viol = 3'd7;
      else if (is_zqcl && mr_written_q != 7'h7F)             viol = 3'd4;
      else if (is_zqcl && cnt_q < c_t_mod)                   viol = 3'd3;
      else if (is_mrs && state_q == S_MRS_SEQ && cnt_q < c_t_mrd) viol = 3'd2;
      else if (is_mrs && state_q == S_XPR && cnt_q < c_t_xpr)     viol = 3'd1;
      else if (is_other)                                     viol = 3'd5;
    end else if (state_q == S_ZQ) begin
      if (!bus.CKE)                                          viol = 3'd6;
      else if (!is_idle)                                     viol = 3'd5;
    end
  end

  always_ff @(posedge CK_t) begin
    if (!reset_n) begin
      state_q      <= S_RST;
      cnt_q        <= '0;
      mr_written_q <= '0;
      init_done_q  <= 1'b0;
      init_err_q   <= 1'b0;
      err_code_q   <= 3'd0;
      for (int i = 0; i < 7; i++) mr_q[i] <= '0;
    end else begin
      case (state_q)
        S_RST: begin
          if (bus.CKE) begin
            state_q <= S_XPR;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_inc;
          end
        end
        S_XPR, S_MRS_SEQ, S_ZQ: begin
          if (viol != 3'd0) begin
            state_q    <= S_ERR;
            cnt_q      <= '0;
            init_err_q <= 1'b1;
            err_code_q <= viol;
          end else if (state_q != S_ZQ && is_mrs) begin
            state_q <= S_MRS_SEQ;
            cnt_q   <= '0;
            for (int i = 0; i < 7; i++) begin
              if (mrs_idx == 3'(i)) begin
                mr_q[i]         <= bus.A;
                mr_written_q[i] <= 1'b1;
              end
            end
          end else if (state_q == S_MRS_SEQ && is_zqcl) begin
            state_q <= S_ZQ;
            cnt_q   <= '0;
          end else if (state_q == S_ZQ && cnt_q == c_zq_last) begin
            state_q     <= S_DONE;
            cnt_q       <= '0;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: cnt_q <= cnt_inc;
      endcase
    end
  end

  assign bus.mr0        = mr_q[0];
  assign bus.mr1        = mr_q[1];
  assign bus.mr2        = mr_q[2];
  assign bus.mr3        = mr_q[3];
  assign bus.mr4        = mr_q[4];
  assign bus.mr5        = mr_q[5];
  assign bus.mr6        = mr_q[6];
  assign bus.mr_written = mr_written_q;
  assign bus.cl_code    = {mr_q[0][6], mr_q[0][5], mr_q[0][4], mr_q[0][2]};
  assign bus.bl_code    = mr_q[0][1:0];
  assign bus.al_code    = mr_q[1][4:3];
  assign bus.cwl_code   = mr_q[2][5:3];
  assign bus.rd_pre     = mr_q[4][11];
  assign bus.wr_pre     = mr_q[4][12];
  assign bus.init_done  = init_done_q;
  assign bus.init_err   = init_err_q;
  assign bus.err_code   = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr_init_responder.sv
// ============================================================================
// tb_ddr_init_responder: directed init sequences with hand-computed results.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ddr_init_responder;

  logic CK_t = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ddr_init_responder_if bus();

  ddr_init_responder dut (
    .CK_t    (CK_t),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 CK_t = ~CK_t;

  // {cs_n, act_n, ras_n, cas_n, we_n}
  localparam logic [4:0] P_NOP = 5'b01111;
  localparam logic [4:0] P_MRS = 5'b01000;
  localparam logic [4:0] P_ZQ  = 5'b01110;
  localparam logic [4:0] P_ACT = 5'b00111;

  logic [2:0] ord [7] = '{3'd3, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};

  function automatic logic [13:0] mrval(input logic [2:0] idx);
    case (idx)
      3'd0:    return 14'h0024;
      3'd1:    return 14'h0018;
      3'd2:    return 14'h0018;
      3'd3:    return 14'h0003;
      3'd4:    return 14'h0800;
      3'd5:    return 14'h0400;
      default: return 14'h0C17;
    endcase
  endfunction

  task automatic step(input logic cke, input logic [4:0] pins,
                      input logic [2:0] idx, input logic [13:0] a);
    bus.CKE = cke;
    {bus.cs_n, bus.act_n, bus.ras_n, bus.cas_n, bus.we_n} = pins;
    bus.BG = {1'b0, idx[2]};
    bus.BA = idx[1:0];
    bus.A  = a;
    @(posedge CK_t);
    #1;
  endtask

  task automatic nops(input int n);
    repeat (n) step(1'b1, P_NOP, 3'd0, 14'h0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1'b0, P_NOP, 3'd0, 14'h0);
    step(1'b0, P_NOP, 3'd0, 14'h0);
    reset_n = 1'b1;
  endtask

  // CKE rise, first MRS 25 cycles later, then n MRS total spaced 9 cycles
  task automatic prefix(input int n);
    step(1'b1, P_NOP, 3'd0, 14'h0);
    nops(24);
    for (int i = 0; i < n; i++) begin
      if (i > 0) nops(8);
      step(1'b1, P_MRS, ord[i], mrval(ord[i]));
    end
  endtask

  task automatic test_reset();
    do_reset();
    nops(3);
    checks++; if (bus.mr_written !== 7'h00) begin errors++;
      $display("FAIL reset_mr_written: got %h expected 00", bus.mr_written); end
    checks++; if ({bus.init_done, bus.init_err, bus.err_code} !== 5'b0) begin errors++;
      $display("FAIL reset_status: got %b expected 00000",
               {bus.init_done, bus.init_err, bus.err_code}); end
    checks++; if (bus.mr0 !== 14'h0) begin errors++;
      $display("FAIL reset_mr0: got %h expected 0000", bus.mr0); end
  endtask

  task automatic test_golden(input string tag);
    prefix(7);
    checks++; if (bus.mr_written !== 7'h7F) begin errors++;
      $display("FAIL %s_mr_written: got %h expected 7f", tag, bus.mr_written); end
    nops(24);
    step(1'b1, P_ZQ, 3'd0, 14'h0400);
    nops(511);
    checks++; if (bus.init_done !== 1'b0) begin errors++;
      $display("FAIL %s_done_early: got %b expected 0", tag, bus.init_done); end
    nops(1);
    checks++; if (bus.init_done !== 1'b1) begin errors++;
      $display("FAIL %s_done: got %b expected 1", tag, bus.init_done); end
    checks++; if (bus.init_err !== 1'b0) begin errors++;
      $display("FAIL %s_err: got %b expected 0", tag, bus.init_err); end
    checks++; if (bus.cl_code !== 4'b0101) begin errors++;
      $display("FAIL %s_cl: got %b expected 0101", tag, bus.cl_code); end
    checks++; if (bus.bl_code !== 2'b00) begin errors++;
      $display("FAIL %s_bl: got %b expected 00", tag, bus.bl_code); end
    checks++; if (bus.cwl_code !== 3'b011) begin errors++;
      $display("FAIL %s_cwl: got %b expected 011", tag, bus.cwl_code); end
    checks++; if (bus.al_code !== 2'b11) begin errors++;
      $display("FAIL %s_al: got %b expected 11", tag, bus.al_code); end
    checks++; if ({bus.rd_pre, bus.wr_pre} !== 2'b10) begin errors++;
      $display("FAIL %s_pre: got %b expected 10", tag, {bus.rd_pre, bus.wr_pre}); end
    checks++; if (bus.mr3 !== 14'h0003 || bus.mr6 !== 14'h0C17) begin errors++;
      $display("FAIL %s_mr3_mr6: got %h %h expected 0003 0c17", tag, bus.mr3, bus.mr6); end
    checks++; if (bus.mr5 !== 14'h0400) begin errors++;
      $display("FAIL %s_mr5: got %h expected 0400", tag, bus.mr5); end
    // MRS after DONE must not touch the stored registers
    step(1'b1, P_MRS, 3'd0, 14'h3FFF);
    nops(2);
    checks++; if (bus.mr0 !== 14'h0024 || bus.init_done !== 1'b1) begin errors++;
      $display("FAIL %s_done_ignores_mrs: got mr0=%h done=%b expected 0024 1",
               tag, bus.mr0, bus.init_done); end
  endtask

  task automatic test_xpr_early();
    do_reset();
    step(1'b1, P_NOP, 3'd0, 14'h0);
    nops(23);
    step(1'b1, P_MRS, 3'd1, 14'h0011);
    checks++; if ({bus.init_err, bus.err_code} !== 4'b1001) begin errors++;
      $display("FAIL xpr_early: got err=%b code=%0d expected 1 1", bus.init_err, bus.err_code); end
    checks++; if (bus.mr_written !== 7'h00) begin errors++;
      $display("FAIL xpr_early_written: got %h expected 00", bus.mr_written); end
  endtask

  task automatic test_mrd_violation();
    do_reset();
    step(1'b1, P_NOP, 3'd0, 14'h0);
    nops(24);
    step(1'b1, P_MRS, 3'd1, 14'h0011);
    nops(4);
    step(1'b1, P_MRS, 3'd1, 14'h0022);
    checks++; if ({bus.init_err, bus.err_code} !== 4'b1010) begin errors++;
      $display("FAIL mrd: got err=%b code=%0d expected 1 2", bus.init_err, bus.err_code); end
    checks++; if (bus.mr1 !== 14'h0011) begin errors++;
      $display("FAIL mrd_mr1: got %h expected 0011", bus.mr1); end
  endtask

  task automatic test_zq_no_mr0();
    do_reset();
    prefix(6);
    nops(24);
    step(1'b1, P_ZQ, 3'd0, 14'h0400);
    checks++; if ({bus.init_err, bus.err_code} !== 4'b1100) begin errors++;
      $display("FAIL zq_no_mr0: got err=%b code=%0d expected 1 4", bus.init_err, bus.err_code); end
    nops(600);
    checks++; if (bus.init_done !== 1'b0 || bus.err_code !== 3'd4) begin errors++;
      $display("FAIL zq_no_mr0_sticky: got done=%b code=%0d expected 0 4",
               bus.init_done, bus.err_code); end
  endtask

  task automatic test_mrs_idx7();
    do_reset();
    prefix(1);
    nops(8);
    step(1'b1, P_MRS, 3'd7, 14'h0155);
    checks++; if ({bus.init_err, bus.err_code} !== 4'b1111) begin errors++;
      $display("FAIL mrs_idx7: got err=%b code=%0d expected 1 7", bus.init_err, bus.err_code); end
  endtask

  task automatic test_act_in_zq();
    do_reset();
    prefix(7);
    nops(24);
    step(1'b1, P_ZQ, 3'd0, 14'h0400);
    nops(99);
    checks++; if (bus.init_err !== 1'b0) begin errors++;
      $display("FAIL zq_nop_ok: got %b expected 0", bus.init_err); end
    step(1'b1, P_ACT, 3'd0, 14'h0);
    checks++; if ({bus.init_err, bus.err_code} !== 4'b1101) begin errors++;
      $display("FAIL act_in_zq: got err=%b code=%0d expected 1 5", bus.init_err, bus.err_code); end
    nops(450);
    checks++; if (bus.init_done !== 1'b0) begin errors++;
      $display("FAIL act_in_zq_done: got %b expected 0", bus.init_done); end
  endtask

  task automatic test_cke_drop();
    do_reset();
    prefix(2);
    step(1'b0, P_NOP, 3'd0, 14'h0);
    checks++; if ({bus.init_err, bus.err_code} !== 4'b1110) begin errors++;
      $display("FAIL cke_drop: got err=%b code=%0d expected 1 6", bus.init_err, bus.err_code); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    prefix(3);
    checks++; if (bus.mr_written !== 7'h68) begin errors++;
      $display("FAIL mid_written: got %h expected 68", bus.mr_written); end
    reset_n = 1'b0;
    step(1'b1, P_NOP, 3'd0, 14'h0);
    reset_n = 1'b1;
    checks++; if (bus.mr_written !== 7'h00 || bus.mr3 !== 14'h0 || bus.mr6 !== 14'h0) begin
      errors++;
      $display("FAIL mid_reset_clear: got written=%h mr3=%h mr6=%h expected 00 0000 0000",
               bus.mr_written, bus.mr3, bus.mr6); end
    checks++; if ({bus.init_done, bus.init_err, bus.err_code} !== 5'b0) begin errors++;
      $display("FAIL mid_reset_status: got %b expected 00000",
               {bus.init_done, bus.init_err, bus.err_code}); end
    // CKE held low after reset keeps the block in RST before the clean rerun
    bus.CKE = 1'b0;
    step(1'b0, P_NOP, 3'd0, 14'h0);
    test_golden("rerun");
  endtask

  initial begin
    bus.CKE = 1'b0;
    {bus.cs_n, bus.act_n, bus.ras_n, bus.cas_n, bus.we_n} = P_NOP;
    bus.BG = 2'b00;
    bus.BA = 2'b00;
    bus.A  = 14'h0;
    test_reset();
    test_golden("golden");
    test_xpr_early();
    test_mrd_violation();
    test_zq_no_mr0();
    test_mrs_idx7();
    test_act_in_zq();
    test_cke_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ddr_init_responder.md
Name: ddr_init_responder

Overview:
- DRAM-side receiver of the DDR4 power-up/initialization sequence, instantiated in the memory model behind the DDR command bus.
- Samples CKE and the command pins every CK_t rising edge and decodes DES/NOP, MRS and ZQCL commands.
- Stores MR0–MR6 and checks JEDEC ordering and spacing: tXPR, tMRD, tMOD, tZQ.
- Publishes the decoded timing fields (CL, CWL, AL, BL, preambles) and an init_done/error status to the model's read/write engines and to the scoreboard.

Parameters:
- T_XPR, 24: minimum cycles from CKE rise to the first MRS.
- T_MRD, 8: minimum cycles between consecutive MRS commands.
- T_MOD, 24: minimum cycles from the last MRS to ZQCL.
- T_ZQ, 512: ZQCL calibration cycles. Only DES/NOP are legal in this window.
- CNT_W, 10: width of the internal interval counter. Must satisfy 2^CNT_W > max(T_XPR, T_MOD, T_ZQ).

Ports:
- CK_t in 1: clock, rising edge.
- reset_n in 1: synchronous active-low reset.
- CKE in 1: clock enable from the controller.
- cs_n, act_n, ras_n, cas_n, we_n in 1 each: command pins.
- BG in 2: bank group.
- BA in 2: bank address.
- A in 14: address bus.
- mr0..mr6 out 14 each: stored mode-register contents.
- mr_written out 7: bit i is set once MRi has been written.
- cl_code out 4: {MR0 A6,A5,A4,A2}.
- bl_code out 2: MR0 A1:A0.
- al_code out 2: MR1 A4:A3.
- cwl_code out 3: MR2 A5:A3.
- rd_pre out 1: MR4 A11.
- wr_pre out 1: MR4 A12.
- init_done out 1: initialization complete. Sticky until reset.
- init_err out 1: protocol violation detected. Sticky until reset.
- err_code out 3: cause of the first violation.

Behaviour:
- Reset: the block is reset when reset_n is sampled low on a CK_t edge.
  - All mrN, mr_written, decoded fields, init_done, init_err and err_code go to 0.
  - State goes to RST and the counter goes to 0.
  - Reset mid-sequence aborts the sequence completely; no partial register state is retained.
- Command decode uses the values sampled at the edge; decoded commands are only valid when CKE=1.
  - DES: cs_n=1.
  - NOP: cs_n=0, act_n=1, ras_n=1, cas_n=1, we_n=1.
  - MRS: cs_n=0, act_n=1, ras_n=0, cas_n=0, we_n=0.
  - ZQCL: cs_n=0, act_n=1, ras_n=1, cas_n=1, we_n=0, A[10]=1.
  - Anything else: OTHER.
- MRS target register index = {BG[0],BA[1],BA[0]}. Index 7 is an illegal MRS.
- Counter: zeroed on every state entry and on every accepted MRS. Otherwise it increments and saturates at all-ones.
- States and transitions:
  - RST: leave when CKE is sampled 1 → XPR.
  - XPR: counter measures time since the CKE rise.
    - MRS with cnt >= T_XPR → MRS_SEQ, accept the MRS.
    - MRS with cnt < T_XPR → ERR, code 1.
  - MRS_SEQ:
    - MRS with cnt >= T_MRD and index <= 6: write mrN <= A, set mr_written[N], restart the counter.
    - MRS with cnt < T_MRD → ERR, code 2.
    - MRS to index 7 → ERR, code 7.
    - Rewriting an already-written MR is legal; the last value wins. MR order is free.
    - ZQCL with mr_written != 7'h7F → ERR, code 4.
    - ZQCL with cnt < T_MOD → ERR, code 3.
    - Otherwise ZQCL → ZQ.
  - ZQ:
    - Any command other than DES/NOP → ERR, code 5.
    - When cnt reaches T_ZQ-1 → DONE. init_done=1 is registered so it is visible on the following edge.
  - DONE: holds.
    - init_done stays 1.
    - All later commands are ignored by this block, including later MRS; the read/write engines handle those.
  - ERR: init_err=1; err_code holds the first cause; the block stays in ERR until reset.
- CKE sampled 0 in XPR, MRS_SEQ or ZQ → ERR, code 6. CKE is not checked in DONE.
- OTHER commands in XPR or MRS_SEQ → ERR, code 5.
- Violation priority within one edge: 6, then 7, then 4, then 3/2/1, then 5.
- Decoded fields are combinational slices of the stored mr registers and are valid once the corresponding mr_written bit is set.
- Output latency: mrN, mr_written and error flags update on the edge after the command is sampled.

Test Plan:
- Golden sequence: CKE rise, MRS after 25 cycles, MR3,6,5,4,2,1,0 spaced 9 cycles, ZQCL 25 cycles after MR0.
  → init_done=1 exactly 512 cycles after ZQCL, init_err=0, mr_written=7'h7F.
  → With MR0 A=14'h0024 and MR2 A=14'h0018: cl_code=4'b0101, bl_code=2'b00, cwl_code=3'b011.
- Two MRS commands 5 cycles apart → init_err=1, err_code=2; mr1 is not updated by the second MRS.
- ZQCL issued with MR0 never written → err_code=4, init_done stays 0.
- MRS to index 7 (BG0=1, BA=2'b11) → err_code=7.
- ACT command 100 cycles into ZQ → err_code=5.
- CKE dropped during MRS_SEQ → err_code=6.
- reset_n low for 1 cycle midway through MRS_SEQ → all outputs 0; a full golden sequence then repeats cleanly to init_done.
